// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Default widths for the performance counters and register addresses.
  localparam int unsigned PIPE_CNT_W = 32;
  localparam int unsigned PIPE_RA_W  = 5;

  // Instruction loaded into a flushed pipeline register (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and async active-low reset.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: joins I-cache and
// D-cache completions, inserts load-use bubbles and squashes on taken branches.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = PIPE_CNT_W,
  parameter int unsigned RA_W  = PIPE_RA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             icache_resp,
  input  logic             dcache_resp,
  input  logic             mem_op,
  input  logic             ex_is_load,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_br_taken,
  output logic             icache_read,
  output logic             dcache_req,
  output logic             load_pc,
  output logic             pc_sel,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic i_seen;
  logic d_seen;
  logic i_ok;
  logic d_ok;
  logic advance;
  logic hz;

  assign i_ok    = icache_resp | i_seen;
  assign d_ok    = !mem_op | dcache_resp | d_seen;
  assign advance = reset & i_ok & d_ok;

  assign hz = ex_is_load & (ex_rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Remember a cache completion until its partner arrives; clear on advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_seen <= 1'b0;
      d_seen <= 1'b0;
    end else if (advance) begin
      i_seen <= 1'b0;
      d_seen <= 1'b0;
    end else begin
      i_seen <= i_ok;
      d_seen <= mem_op & (dcache_resp | d_seen);
    end
  end

  // Request, load and flush strobes; everything is held low during reset.
  always_comb begin
    icache_read = 1'b0;
    dcache_req  = 1'b0;
    load_pc     = 1'b0;
    pc_sel      = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (reset) begin
      icache_read = !i_seen;
      dcache_req  = mem_op & !d_seen;
      if (advance) begin
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
        load_id_ex  = 1'b1;
        if (ex_br_taken) begin
          // Taken branch squashes the ID instruction, so a hazard is moot.
          load_pc     = 1'b1;
          pc_sel      = 1'b1;
          load_if_id  = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (hz) begin
          flush_id_ex = 1'b1;
        end else begin
          load_pc    = 1'b1;
          load_if_id = 1'b1;
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!advance),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (advance & ex_br_taken),
    .clear (1'b0),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic       icache_resp, dcache_resp, mem_op, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, ex_br_taken;
  logic       icache_read, dcache_req, load_pc, pc_sel;
  logic       load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic       flush_if_id, flush_id_ex;
  logic [31:0] stall_cnt, flush_cnt;

  logic       s_reset;
  logic       s_icache_read, s_dcache_req, s_load_pc, s_pc_sel;
  logic       s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
  logic       s_flush_if_id, s_flush_id_ex;
  logic [3:0] s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int fails = 0;

  pipeline_ctrl #(.CNT_W(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset),
    .icache_resp(icache_resp), .dcache_resp(dcache_resp), .mem_op(mem_op),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_br_taken(ex_br_taken),
    .icache_read(icache_read), .dcache_req(dcache_req), .load_pc(load_pc),
    .pc_sel(pc_sel), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter build left idle so it stalls every cycle.
  pipeline_ctrl #(.CNT_W(4), .RA_W(5)) dut_sat (
    .clk(clk), .reset(s_reset),
    .icache_resp(1'b0), .dcache_resp(1'b0), .mem_op(1'b0),
    .ex_is_load(1'b0), .ex_rd(5'd0), .id_rs1(5'd0), .id_rs2(5'd0),
    .id_use_rs1(1'b0), .id_use_rs2(1'b0), .ex_br_taken(1'b0),
    .icache_read(s_icache_read), .dcache_req(s_dcache_req), .load_pc(s_load_pc),
    .pc_sel(s_pc_sel), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
    .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // {icache_read, dcache_req, load_pc, pc_sel, load_if_id, load_id_ex,
  //  load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
  logic [9:0] outs, s_outs;
  assign outs = {icache_read, dcache_req, load_pc, pc_sel, load_if_id,
                 load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};
  assign s_outs = {s_icache_read, s_dcache_req, s_load_pc, s_pc_sel, s_load_if_id,
                   s_load_id_ex, s_load_ex_mem, s_load_mem_wb, s_flush_if_id,
                   s_flush_id_ex};

  typedef struct {
    logic       ir, dr, mo, ld;
    logic [4:0] rd, r1, r2;
    logic       u1, u2, br;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic ir, logic dr, logic mo, logic ld,
                              logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                              logic u1, logic u2, logic br, logic [9:0] exp);
    vec_t v;
    v.ir = ir; v.dr = dr; v.mo = mo; v.ld = ld;
    v.rd = rd; v.r1 = r1; v.r2 = r2;
    v.u1 = u1; v.u2 = u2; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    icache_resp = v.ir; dcache_resp = v.dr; mem_op = v.mo; ex_is_load = v.ld;
    ex_rd = v.rd; id_rs1 = v.r1; id_rs2 = v.r2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_br_taken = v.br;
  endtask

  task automatic set_simple(input logic ir, input logic dr, input logic mo);
    drive(mk(ir, dr, mo, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 10'd0));
  endtask

  logic [31:0] base;

  initial begin
    tbl[0]  = mk(1,0,0, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1010111100); // plain hit
    tbl[1]  = mk(1,1,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1110111100); // both respond together
    tbl[2]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1000000000); // fetch miss
    tbl[3]  = mk(1,0,0, 1, 5'd5, 5'd5, 5'd0, 1,0, 0, 10'b1000011101); // load-use rs1
    tbl[4]  = mk(1,0,0, 1, 5'd7, 5'd0, 5'd7, 0,1, 0, 10'b1000011101); // load-use rs2
    tbl[5]  = mk(1,0,0, 1, 5'd0, 5'd0, 5'd0, 1,1, 0, 10'b1010111100); // x0 never hazards
    tbl[6]  = mk(1,0,0, 1, 5'd5, 5'd5, 5'd5, 0,0, 0, 10'b1010111100); // sources unused
    tbl[7]  = mk(1,0,0, 0, 5'd5, 5'd5, 5'd0, 1,0, 0, 10'b1010111100); // not a load
    tbl[8]  = mk(1,0,0, 1, 5'd5, 5'd5, 5'd0, 1,0, 1, 10'b1011111111); // branch over hazard
    tbl[9]  = mk(0,0,0, 0, 5'd0, 5'd0, 5'd0, 0,0, 1, 10'b1000000000); // branch while frozen
    tbl[10] = mk(1,0,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1100000000); // I first, D pending
    tbl[11] = mk(0,0,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b0100000000); // I held
    tbl[12] = mk(0,1,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b0110111100); // D completes
    tbl[13] = mk(0,1,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1100000000); // D first
    tbl[14] = mk(0,0,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1000000000); // D held
    tbl[15] = mk(1,0,1, 0, 5'd0, 5'd0, 5'd0, 0,0, 0, 10'b1010111100); // I completes

    reset = 1'b0;
    s_reset = 1'b0;
    set_simple(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    #2;
    check("reset_outputs", {22'd0, outs}, 32'd0);
    check("reset_stall_cnt", stall_cnt, 32'd0);
    check("reset_flush_cnt", flush_cnt, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i]);
      #2;
      check($sformatf("vec%0d", i), {22'd0, outs}, {22'd0, tbl[i].exp});
      @(negedge clk);
    end
    check("table_stall_cnt", stall_cnt, 32'd6);
    check("table_flush_cnt", flush_cnt, 32'd1);

    // Back-to-back hits.
    base = stall_cnt;
    for (int i = 0; i < 10; i++) begin
      set_simple(1'b1, 1'b0, 1'b0);
      #2;
      check($sformatf("b2b%0d", i), {22'd0, outs}, {22'd0, 10'b1010111100});
      @(negedge clk);
    end
    check("b2b_stall", stall_cnt - base, 32'd0);

    // Split responses: I in cycle 2, D in cycle 5.
    base = stall_cnt;
    for (int c = 2; c <= 5; c++) begin
      set_simple(c == 2, c == 5, 1'b1);
      #2;
      check($sformatf("split_adv_c%0d", c), {31'd0, load_pc}, {31'd0, c == 5});
      check($sformatf("split_iread_c%0d", c), {31'd0, icache_read}, {31'd0, c == 2});
      @(negedge clk);
    end
    check("split_stall", stall_cnt - base, 32'd3);

    // Load-use bubble then normal advance.
    drive(mk(1,1,1, 1, 5'd5, 5'd5, 5'd0, 1,0, 0, 10'd0));
    #2;
    check("lu_bubble", {22'd0, outs}, {22'd0, 10'b1100011101});
    @(negedge clk);
    drive(mk(1,1,1, 0, 5'd5, 5'd5, 5'd0, 1,0, 0, 10'd0));
    #2;
    check("lu_next", {22'd0, outs}, {22'd0, 10'b1110111100});
    @(negedge clk);

    // Branch overrides hazard; flush counter steps once.
    base = flush_cnt;
    drive(mk(1,0,0, 1, 5'd9, 5'd0, 5'd9, 0,1, 1, 10'd0));
    #2;
    check("br_over_hz", {22'd0, outs}, {22'd0, 10'b1011111111});
    @(negedge clk);
    set_simple(1'b1, 1'b0, 1'b0);
    check("br_flush_cnt", flush_cnt - base, 32'd1);

    // Async reset while waiting on the D-cache with the I response held.
    set_simple(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    set_simple(1'b0, 1'b0, 1'b1);
    #2;
    check("wait_iread_dropped", {31'd0, icache_read}, 32'd0);
    #2;
    reset = 1'b0;
    #2;
    check("midreset_outputs", {22'd0, outs}, 32'd0);
    check("midreset_stall", stall_cnt, 32'd0);
    check("midreset_flush", flush_cnt, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rerequest_outputs", {22'd0, outs}, {22'd0, 10'b1100000000});
    check("rerequest_stall", stall_cnt, 32'd0);
    @(negedge clk);
    check("post_reset_stall", stall_cnt, 32'd1);

    // Saturation on the 4-bit build.
    s_reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("sat%0d", k), {28'd0, s_stall_cnt}, (k > 15) ? 32'd15 : k);
    end
    check("sat_flush", {28'd0, s_flush_cnt}, 32'd0);
    check("sat_outputs", {22'd0, s_outs}, {22'd0, 10'b1000000000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Generates the load and flush strobes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC load/select.
- Coordinates I-cache and D-cache responses that may complete in different cycles, and handles load-use hazards and taken branches.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- icache_resp  in  1  I-cache read complete, pulse
- dcache_resp  in  1  D-cache access complete, pulse
- mem_op  in  1  MEM-stage instruction performs a load or store
- ex_is_load  in  1  EX-stage instruction is a load
- ex_rd  in  RA_W  EX-stage destination register
- id_rs1, id_rs2  in  RA_W  ID-stage source registers
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2
- ex_br_taken  in  1  EX-stage branch/jump resolved taken
- icache_read  out  1  fetch request
- dcache_req  out  1  MEM-stage data request enable
- load_pc  out  1  PC register load
- pc_sel  out  1  0 = PC+4, 1 = branch target
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1  pipeline register loads
- flush_if_id, flush_id_ex  out  1  insert bubble (NOP) on load
- stall_cnt  out  CNT_W  cycles with advance=0
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- State: flags i_seen and d_seen, plus the two counters. All reset asynchronously on reset=0 to 0.
- Outputs are combinational from the flags and inputs. During reset every output is 0 and the counters read 0.
- i_ok = icache_resp | i_seen.
- d_ok = !mem_op | dcache_resp | d_seen.
- advance = i_ok & d_ok.
- Flag updates:
  - If advance: both flags clear next cycle.
  - Otherwise: i_seen <= i_ok and d_seen <= (mem_op & (dcache_resp | d_seen)).
  - A response arriving before its partner is held until the partner completes; it is never lost and never double-counted.
- Request strobes:
  - icache_read = !i_seen.
  - dcache_req = mem_op & !d_seen.
  - A satisfied request is dropped until the next advance.
- Hazard term: hz = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- If advance=0: all loads 0, flushes 0, pc_sel 0. The pipeline is frozen.
- If advance=1 and ex_br_taken=1 (highest priority):
  - All four register loads = 1, load_pc = 1, pc_sel = 1.
  - flush_if_id = 1, flush_id_ex = 1.
  - hz is ignored because the ID instruction is squashed.
- If advance=1, ex_br_taken=0, hz=1:
  - load_pc = 0, load_if_id = 0 (hold).
  - load_id_ex = 1 with flush_id_ex = 1 (bubble).
  - load_ex_mem = 1, load_mem_wb = 1.
  - Exactly a one-cycle bubble.
- If advance=1 with no hazard: all loads 1, load_pc = 1, pc_sel = 0, flushes 0.
- Counters:
  - stall_cnt increments on every post-reset cycle with advance=0.
  - flush_cnt increments on each advance & ex_br_taken.
  - Both saturate at all-ones and do not wrap.
- Reset mid-wait: flags clear. After release the controller re-requests both caches; the caches drop outstanding transactions on the same reset.
- Simultaneous icache_resp and dcache_resp in one cycle: advance in that cycle, flags stay 0.
- mem_op=0 with d_seen stale cannot occur: d_seen clears on advance, and MEM contents change only on advance.

Decomposition:
- Shared package pipe_ctrl_pkg: RA_W, CNT_W, and the NOP encoding constant used by the flushed registers.
- One sub-module, sat_counter (parameterised width, inc, clear). It is instantiated twice for stall_cnt and flush_cnt.
- The remaining logic is flat.

Test Plan:
- Back-to-back hits: icache_resp=1 every cycle, mem_op=0, no hazards for 10 cycles -> all loads 1 every cycle, stall_cnt=0.
- Split responses: mem_op=1, icache_resp at cycle 2, dcache_resp at cycle 5 -> advance only in cycle 5; icache_read=0 in cycles 3-5; stall_cnt=3.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1, both caches hit -> load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1 for one cycle; next cycle, with ex_is_load=0, normal advance.
- Branch overrides hazard: hazard condition plus ex_br_taken=1 -> pc_sel=1, flush_if_id=1, flush_id_ex=1, all loads 1; flush_cnt increments by 1.
- Async reset mid-wait: i_seen=1, pulse reset low between clock edges -> outputs and flags 0 immediately; after release icache_read=1 and stall_cnt=0.
- Saturation: preload via CNT_W=4 build, 20 stall cycles -> stall_cnt holds at 15.
